// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: state type and framing helpers for serial_rx_frame.
// frame_len() is shared with benches.
package serial_rx_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAR  = 3'd2,
    S_STOP = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } rx_state_t;

  // Line bits per frame: start + data + optional parity + stops.
  function automatic int frame_len(
    input int data_w,
    input int stop_bits,
    input int par
  );
    return 1 + data_w + par + stop_bits;
  endfunction

endpackage

// File: rtl/serial_rx_frame.sv
// serial_rx_frame: one-bit-per-clock serial frame receiver.
// Optional parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx_frame
  import serial_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] out_byte,
  output logic              done,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS > 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  bit_pos;
  logic              start;
  logic              last_stop;
  logic              par_ok;

  // A 0 seen while idle or just after a frame is a start bit.
  assign start = ((state == S_IDLE) || (state == S_DONE)) && !in;

  // Final stop bit sampled as 1: the frame completes on this edge.
  assign last_stop = (state == S_STOP) && in &&
                     (stop_cnt == STOP_LAST);

  assign busy = (state != S_IDLE) && (state != S_ERR);

  // Word position written by the current data bit.
  always_comb begin
    bit_pos = bit_cnt;
    if (MSB_FIRST != 0) bit_pos = CNT_LAST - bit_cnt;
  end

  // Frame FSM with shifter, bit/stop counters and output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      data      <= '0;
      out_byte  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          data[bit_pos] <= in;
          if (bit_cnt == CNT_LAST) begin
            stop_cnt <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            state    <= S_PAR;
`else
            state    <= S_STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PAR: begin
          state <= S_STOP;
        end
        S_STOP: begin
          if (!in) begin
            state     <= S_ERR;
            frame_err <= 1'b1;
          end else if (last_stop) begin
            state <= S_DONE;
            done  <= par_ok;
            if (par_ok) out_byte <= data;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ERR: begin
          if (in) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);

  logic par_acc;
  logic par_bad;

  // Running parity of data bits; mismatch latched in PAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= last_stop && par_bad;
      if (start) begin
        par_acc <= 1'b0;
      end else if (state == S_DATA) begin
        par_acc <= par_acc ^ in;
      end
      if (state == S_PAR) begin
        par_bad <= in ^ par_acc ^ ODD;
      end
    end
  end

  assign par_ok = !par_bad;
`else
  logic unused_par_odd;

  assign unused_par_odd = (PARITY_ODD != 0);
  assign par_ok         = 1'b1;
  assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_frame.sv
// tb_serial_rx_frame: frame-level reference model vs serial_rx_frame.
// Lanes: u0 default, u1 MSB first, u2 5 data bits / 2 stop bits.
`timescale 1ns/1ps
module tb_serial_rx_frame;
  import serial_rx_pkg::*;

`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  // kind: 1 done, 2 frame_err, 3 parity_err; val is out_byte
  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] t;
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  lin   = 3'b111;
  logic [2:0]  dn;
  logic [2:0]  fe;
  logic [2:0]  pe;
  logic [2:0]  bz;
  logic [7:0]  ob0;
  logic [7:0]  ob1;
  logic [4:0]  ob2;
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last [3];
  ev_t         obs [$];
  ev_t         exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_frame u0 (
    .clk(clk), .reset(reset), .in(lin[0]),
    .out_byte(ob0), .done(dn[0]), .frame_err(fe[0]),
    .parity_err(pe[0]), .busy(bz[0])
  );

  serial_rx_frame #(.MSB_FIRST(1)) u1 (
    .clk(clk), .reset(reset), .in(lin[1]),
    .out_byte(ob1), .done(dn[1]), .frame_err(fe[1]),
    .parity_err(pe[1]), .busy(bz[1])
  );

  serial_rx_frame #(.DATA_W(5), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .in(lin[2]),
    .out_byte(ob2), .done(dn[2]), .frame_err(fe[2]),
    .parity_err(pe[2]), .busy(bz[2])
  );

  function automatic int lw(input int l);
    return (l == 2) ? 5 : 8;
  endfunction

  function automatic int lsb_n(input int l);
    return (l == 2) ? 2 : 1;
  endfunction

  function automatic logic [31:0] obv(input int l);
    case (l)
      0:       return 32'(ob0);
      1:       return 32'(ob1);
      default: return 32'(ob2);
    endcase
  endfunction

  // Log every strobe seen on any lane.
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (dn[l])
        obs.push_back(ev_t'({2'(l), 32'(cyc), 2'd1, obv(l)}));
      if (fe[l])
        obs.push_back(ev_t'({2'(l), 32'(cyc), 2'd2, obv(l)}));
      if (pe[l])
        obs.push_back(ev_t'({2'(l), 32'(cyc), 2'd3, obv(l)}));
    end
  end

  task automatic put(input int l, input logic b);
    lin[l] = b;
    @(negedge clk);
  endtask

  // Send one frame and predict its outcome from the framing rules.
  // stops[j] is the j-th stop bit; the frame ends at the first 0.
  task automatic drive_frame(
    input int l, input logic [31:0] word, input logic [1:0] stops,
    input logic pbit, input int hold0, input int gap
  );
    int w, sb, s, bad_j;
    logic [31:0] m;
    logic ok;
    w = lw(l);
    sb = lsb_n(l);
    s = cyc;
    m = (32'd1 << w) - 32'd1;
    bad_j = -1;
    put(l, 1'b0);
    for (int i = 0; i < w; i++)
      put(l, (l == 1) ? word[w-1-i] : word[i]);
    if (PB != 0) put(l, pbit);
    for (int j = 0; j < sb; j++) begin
      put(l, stops[j]);
      if (!stops[j]) begin
        bad_j = j;
        break;
      end
    end
    if (bad_j >= 0) begin
      exp_q.push_back(ev_t'({2'(l), 32'(s + 2 + w + PB + bad_j),
                             2'd2, last[l]}));
      repeat (hold0) put(l, 1'b0);
      put(l, 1'b1);
    end else begin
      ok = (PB == 0) || ((^(word & m)) == pbit);
      if (ok) begin
        last[l] = word & m;
        exp_q.push_back(ev_t'({2'(l), 32'(s + 1 + w + PB + sb),
                               2'd1, last[l]}));
      end else begin
        exp_q.push_back(ev_t'({2'(l), 32'(s + 1 + w + PB + sb),
                               2'd3, last[l]}));
      end
    end
    repeat (gap) put(l, 1'b1);
  endtask

  task automatic test_reset();
    for (int l = 0; l < 3; l++) last[l] = '0;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      n_cmp++;
      if ({dn[l], fe[l], pe[l], bz[l]} !== 4'b0 || obv(l) !== 0) begin
        n_bad++;
        $display("FAIL reset lane%0d: flags=%b out=%h, want 0000 0",
                 l, {dn[l], fe[l], pe[l], bz[l]}, obv(l));
      end
    end
    obs.delete();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    drive_frame(0, 32'h00, 2'b11, 1'b0, 0, 0);
    drive_frame(0, 32'h55, 2'b11, ^8'h55, 0, 3);
    drive_frame(1, 32'hAA, 2'b11, ^8'hAA, 0, 3);
    repeat (2) put(0, 1'b1);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic ev%0d: got %h want %h (lane,t,kind,val)",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_err();
    drive_frame(0, 32'h5A, 2'b10, ^8'h5A, 5, 0);
    drive_frame(0, 32'h81, 2'b11, ^8'h81, 0, 0);
    repeat (2) put(0, 1'b1);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL frame_err count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL frame_err ev%0d: got %h want %h",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int gap;
    drive_frame(0, 32'h3C, 2'b11, ^8'h3C, 0, 0);
    drive_frame(0, 32'hC3, 2'b11, ^8'hC3, 0, 0);
    repeat (2) put(0, 1'b1);
    gap = (obs.size() >= 2) ? int'(obs[1].t - obs[0].t) : -1;
    n_cmp++;
    if (gap != frame_len(8, 1, PB)) begin
      n_bad++;
      $display("FAIL b2b spacing: got %0d want %0d",
               gap, frame_len(8, 1, PB));
    end
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL b2b ev%0d: got %h want %h",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_wide_stop();
    drive_frame(2, 32'h15, 2'b01, ^5'h15, 0, 1);
    drive_frame(2, 32'h0A, 2'b11, ^5'h0A, 0, 0);
    repeat (2) put(2, 1'b1);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL stop2 count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stop2 ev%0d: got %h want %h",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    drive_frame(0, 32'h3C, 2'b11, 1'b0, 0, 1);
    drive_frame(0, 32'h07, 2'b11, 1'b0, 0, 0);
    drive_frame(0, 32'h07, 2'b11, 1'b1, 0, 0);
    repeat (2) put(0, 1'b1);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL parity count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL parity ev%0d: got %h want %h",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int l;
      logic [31:0] word;
      logic [1:0] st;
      logic pb;
      l = $urandom_range(0, 2);
      word = $urandom & ((32'd1 << lw(l)) - 32'd1);
      st = 2'b11;
      if ($urandom_range(0, 3) == 0)
        st = (lsb_n(l) == 2 && $urandom_range(0, 1) == 1)
             ? 2'b01 : 2'b10;
      pb = ^word;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      drive_frame(l, word, st, pb,
                  $urandom_range(0, 3), $urandom_range(0, 2));
    end
    repeat (2) put(0, 1'b1);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random ev%0d: got %h want %h",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    put(0, 1'b0);
    put(0, 1'b1);
    put(0, 1'b0);
    put(0, 1'b1);
    n_cmp++;
    if (bz[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy in data: got %b want 1", bz[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      n_cmp++;
      if ({dn[l], fe[l], pe[l], bz[l]} !== 4'b0 || obv(l) !== 0) begin
        n_bad++;
        $display("FAIL midreset lane%0d: flags=%b out=%h, want 0000 0",
                 l, {dn[l], fe[l], pe[l], bz[l]}, obv(l));
      end
      last[l] = '0;
    end
    obs.delete();
    reset = 1'b0;
    drive_frame(0, 32'hA5, 2'b11, ^8'hA5, 0, 0);
    repeat (2) put(0, 1'b1);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL midreset count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midreset ev%0d: got %h want %h",
                 i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_wide_stop();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_frame.md
# serial_rx_frame

Parametrised synchronous serial frame receiver, successor to the fixed 8-bit `fsm_serial`. It samples one line bit per clock and detects a start bit (0). It then shifts in `DATA_W` data bits, optionally checks a parity bit, and checks `STOP_BITS` stop bits (1). It presents the assembled word with a one-cycle `done` strobe and reports framing errors. It sits between a line synchroniser and the byte consumer.

## Interface
- `DATA_W`, 8: data bits per frame, 1..32.
- `STOP_BITS`, 1: required stop bits, 1 or 2.
- `MSB_FIRST`, 0: 0 means first data bit is bit 0 (LSB); 1 means first data bit is bit `DATA_W-1`.
- `PARITY_ODD`, 0: 0 means even parity, 1 means odd parity. Used only with `SERIAL_RX_PARITY_EN`.
- `clk` in 1: clock; all sampling on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in` in 1: serial line; idle level is 1.
- `out_byte` out `DATA_W`: last accepted word.
- `done` out 1: one-cycle strobe, frame accepted.
- `frame_err` out 1: one-cycle strobe, stop bit sampled as 0.
- `parity_err` out 1: one-cycle strobe, parity mismatch. Tied to 0 without the macro.
- `busy` out 1: high in every state except IDLE and ERR.

## Operation
- States: IDLE, DATA, PAR, STOP, DONE, ERR. PAR exists only with the macro.
- **IDLE**
  - `in`=0 → DATA, bit counter cleared.
  - Otherwise stay in IDLE.
- **DATA**
  - Shift `in` into the data register at the position set by `MSB_FIRST`.
  - After the `DATA_W`-th bit: → PAR if the macro is set, else → STOP.
- **PAR**
  - Compare `in` against the computed parity; store the mismatch flag.
  - → STOP.
- **STOP**
  - Sample `in` once per stop bit.
  - Any 0 sample → ERR immediately; `frame_err` pulses in the first ERR cycle.
  - After `STOP_BITS` samples of 1 → DONE.
- **DONE**
  - If parity is OK: `done`=1 and `out_byte` loads the data register.
  - If parity is bad: `parity_err`=1 instead; `done`=0 and `out_byte` is unchanged.
  - `in`=0 → DATA (back-to-back frame; this sample is the new start bit).
  - `in`=1 → IDLE.
- **ERR**
  - Wait for `in`=1, then → IDLE.
  - A 0 seen in ERR is never taken as a start bit.
- `out_byte` holds its value between accepted frames.
- Reset values: state IDLE; `out_byte`=0; `done`=0; `frame_err`=0; `parity_err`=0; `busy`=0; counters and data register 0.

## Timing
- Frame length N = 1 + `DATA_W` + P + `STOP_BITS`, where P=1 with the macro and 0 without it.
- Edge 0 samples the start bit. `done` is high for exactly the one cycle following the edge that samples the last stop bit.
- `out_byte` changes on the same edge that `done` rises.
- `done`, `frame_err` and `parity_err` are registered and mutually exclusive.
- Back-to-back frames need no idle cycle; the maximum accepted rate is one frame per N cycles.
- `reset` overrides `in` and all transitions, including mid-frame. The edge after deassertion samples from IDLE.
- The bit counter saturates at `DATA_W-1` and is cleared on entry to DATA; it never wraps.

## Configuration
- `SERIAL_RX_PARITY_EN`, when defined:
  - adds the PAR state and one parity bit after the data bits;
  - a mismatch suppresses `done` and pulses `parity_err`.
- When undefined:
  - no PAR state; frames carry no parity bit;
  - `parity_err` is constant 0 and `PARITY_ODD` is ignored.

## Structure
- Package `serial_rx_pkg`:
  - state enum `rx_state_t`;
  - localparams for state encoding width;
  - function `frame_len(data_w, stop_bits, par)`, shared with benches.
- No sub-module. Shifter, bit counter, stop counter and parity accumulator live in the FSM module.

## Test plan
- Defaults, no macro:
  - `reset`=1 for 1 cycle, then `in`=0 for 9 cycles (start + 8 zero bits), then `in`=1 → `done`=1 for one cycle 10 cycles after reset release, `out_byte`=0x00.
  - Frame 0x55 sent LSB first, then stop 1 → `out_byte`=0x55, `done` 1 cycle.
  - With `MSB_FIRST`=1, the same bits give `out_byte`=0xAA.
- Stop bit sampled 0 → `frame_err` pulses once and `done` stays 0. Line held 0 for 5 more cycles: no new frame starts. Then `in`=1 → back to IDLE, and the next valid frame is received.
- Two frames 0x3C and 0xC3 with zero idle cycles between them → two `done` pulses exactly 10 cycles apart, with matching `out_byte` values.
- `DATA_W`=5, `STOP_BITS`=2: second stop bit 0 → `frame_err`, no `done`. Both stop bits 1 → `done` at the 8th cycle after the start edge.
- Macro defined, even parity:
  - 0x07 with parity bit 1 → `done`, `out_byte`=0x07.
  - 0x07 with parity bit 0 → `parity_err`, `out_byte` keeps its previous value.
- `reset` asserted mid-DATA → next cycle all outputs are 0. A frame starting right after release is received correctly.
